// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lsu_ctrl
// Brief    : Load/store unit; initiates dm_* transactions, splits misaligned
//            accesses into byte transactions and reassembles load data.
// Revision : 1.0
// ============================================================================
module lsu_ctrl #(
    parameter int MEM_BYTES   = 16384,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  dm_rd_ctrl,
    output logic [1:0]  dm_wr_ctrl,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_SPLIT  = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic        r_uns;
    logic [1:0]  r_size;
    logic [1:0]  r_k;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_asm;

    logic [32:0] w_nbytes;
    logic [32:0] w_last_byte;
    logic        w_misaligned;
    logic        w_err;
    logic [2:0]  w_rd_ctrl;
    logic [31:0] w_din;

    logic [1:0]  w_k_next;
    logic        w_k_last;
    logic [31:0] w_asm_next;
    logic [31:0] w_split_rdata;

    always_comb begin
        w_nbytes     = 33'd1;
        w_rd_ctrl    = req_unsigned ? 3'b010 : 3'b001;
        w_din        = {4{req_wdata[7:0]}};
        w_misaligned = 1'b0;
        case (req_size)
            2'b01: begin
                w_nbytes     = 33'd2;
                w_rd_ctrl    = req_unsigned ? 3'b100 : 3'b011;
                w_din        = {2{req_wdata[15:0]}};
                w_misaligned = req_addr[0];
            end
            2'b10: begin
                w_nbytes     = 33'd4;
                w_rd_ctrl    = 3'b101;
                w_din        = req_wdata;
                w_misaligned = |req_addr[1:0];
            end
            default: ;
        endcase
    end

    // 33-bit sum so that a wrap past 2^32 lands above MEM_BYTES
    assign w_last_byte = {1'b0, req_addr} + w_nbytes - 33'd1;
    assign w_err = (req_size == 2'b11) || (w_last_byte >= 33'(MEM_BYTES)) ||
                   (w_misaligned && !MISALIGN_EN);

    assign w_k_next = r_k + 2'd1;
    assign w_k_last = (r_k == ((r_size == 2'b10) ? 2'd3 : 2'd1));

    always_comb begin
        w_asm_next                      = r_asm;
        w_asm_next[{r_k, 3'b000} +: 8]  = dm_dout[7:0];
    end

    always_comb begin
        w_split_rdata = w_asm_next;
        if (r_size == 2'b01) begin
            w_split_rdata = r_uns ? {16'h0, w_asm_next[15:0]}
                                  : {{16{w_asm_next[15]}}, w_asm_next[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_uns      <= 1'b0;
            r_size     <= 2'b00;
            r_k        <= 2'd0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_asm      <= 32'h0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'h0;
            dm_rd_ctrl <= 3'b000;
            dm_wr_ctrl <= 2'b00;
            dm_addr    <= 32'h0;
            dm_din     <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        r_we      <= req_we;
                        r_uns     <= req_unsigned;
                        r_size    <= req_size;
                        r_addr    <= req_addr;
                        r_wdata   <= req_wdata;
                        r_k       <= 2'd0;
                        r_asm     <= 32'h0;
                        req_ready <= 1'b0;
                        if (w_err) begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'h0;
                        end else begin
                            r_state <= w_misaligned ? S_SPLIT : S_ACCESS;
                            dm_addr <= req_addr;
                            if (req_we) begin
                                dm_wr_ctrl <= w_misaligned ? 2'b01 : (req_size + 2'd1);
                                dm_din     <= w_misaligned ? {4{req_wdata[7:0]}} : w_din;
                            end else begin
                                dm_rd_ctrl <= w_misaligned ? 3'b010 : w_rd_ctrl;
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    r_state    <= S_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= r_we ? 32'h0 : dm_dout;
                    dm_rd_ctrl <= 3'b000;
                    dm_wr_ctrl <= 2'b00;
                    dm_addr    <= 32'h0;
                    dm_din     <= 32'h0;
                end
                S_SPLIT: begin
                    if (!r_we) begin
                        r_asm <= w_asm_next;
                    end
                    if (w_k_last) begin
                        r_state    <= S_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= r_we ? 32'h0 : w_split_rdata;
                        dm_rd_ctrl <= 3'b000;
                        dm_wr_ctrl <= 2'b00;
                        dm_addr    <= 32'h0;
                        dm_din     <= 32'h0;
                    end else begin
                        r_k     <= w_k_next;
                        dm_addr <= r_addr + 32'(w_k_next);
                        if (r_we) begin
                            dm_din <= {4{r_wdata[{w_k_next, 3'b000} +: 8]}};
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'h0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
